// File: rtl/modexp_ctrl_pkg.sv
// keychain_pkg: types and defaults shared by the modular-exponentiation
// sequencer, its exponent scanner and the datapath-unit handshake interface.
package keychain_pkg;

   localparam int unsigned DEF_WIDTH     = 16;  // operand / modulus width
   localparam int unsigned DEF_EXP_WIDTH = 16;  // exponent width

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SQ_ISSUE,
      SQ_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      NEXT,
      DONE
   } modexp_state_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if: ready/busy/valid handshake between the exponentiation
// sequencer and the external modular squarer and multiplier.
//   master : sequencer side (drives triggers and operands, takes results)
//   slave  : datapath-unit side
//   sq_*   : squarer trigger, operand, modulus, result, done pulse
//   mul_*  : multiplier trigger, operands a/b, modulus, result, done pulse
interface modexp_ctrl_if
   import keychain_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             sq_ready_out;
   logic [WIDTH-1:0] sq_value_out;
   logic [WIDTH-1:0] sq_modulus_out;
   logic [WIDTH-1:0] sq_result_in;
   logic             sq_valid_in;

   logic             mul_ready_out;
   logic [WIDTH-1:0] mul_a_out;
   logic [WIDTH-1:0] mul_b_out;
   logic [WIDTH-1:0] mul_modulus_out;
   logic [WIDTH-1:0] mul_result_in;
   logic             mul_valid_in;

   modport master (
      output sq_ready_out, sq_value_out, sq_modulus_out,
      input  sq_result_in, sq_valid_in,
      output mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out,
      input  mul_result_in, mul_valid_in
   );

   modport slave (
      input  sq_ready_out, sq_value_out, sq_modulus_out,
      output sq_result_in, sq_valid_in,
      input  mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out,
      output mul_result_in, mul_valid_in
   );
endinterface

// File: rtl/modexp_ctrl_exp_bit_scanner.sv
// exp_bit_scanner: holds the exponent being scanned MSB-first and the count
// of bits not yet consumed.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_value, bits_left = EXP_WIDTH
//   shift       : shift exponent left one bit, bits_left - 1
//   msb         : current top bit of the exponent
//   empty       : no bits left
//   last        : exactly one bit left (next shift empties the scanner)
module exp_bit_scanner
   import keychain_pkg::*;
#(
   parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift,
   input  logic [EXP_WIDTH-1:0] load_value,
   output logic                 msb,
   output logic                 empty,
   output logic                 last
);
   localparam int unsigned CNT_W = $clog2(EXP_WIDTH + 1);

   logic [EXP_WIDTH-1:0] exp_sh;
   logic [CNT_W-1:0]     bits_left;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_sh    <= '0;
         bits_left <= '0;
      end else if (load) begin
         exp_sh    <= load_value;
         bits_left <= CNT_W'(EXP_WIDTH);
      end else if (shift) begin
         exp_sh    <= exp_sh << 1;
         bits_left <= bits_left - CNT_W'(1);
      end
   end

   assign msb   = exp_sh[EXP_WIDTH-1];
   assign empty = (bits_left == '0);
   assign last  = (bits_left == CNT_W'(1));
endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: computes base^exponent mod modulus by left-to-right
// square-and-multiply, driving an external squarer and multiplier.
//   clk_in, rst_n_in          : clock, asynchronous active-low reset
//   start_in                  : request, sampled only in IDLE
//   base_in/exponent_in/modulus_in : operands captured on accepted start
//   result_out                : result, held until the next completion
//   busy_out                  : job in progress
//   valid_out                 : one-cycle completion pulse
//   error_out                 : modulus was zero (with valid_out)
//   unit                      : squarer / multiplier handshake
module modexp_ctrl
   import keychain_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [WIDTH-1:0]     base_in,
   input  logic [EXP_WIDTH-1:0] exponent_in,
   input  logic [WIDTH-1:0]     modulus_in,
   output logic [WIDTH-1:0]     result_out,
   output logic                 busy_out,
   output logic                 valid_out,
   output logic                 error_out,
   modexp_ctrl_if.master        unit
);
   modexp_state_t    state, next_state;
   logic [WIDTH-1:0] acc, base_q, mod_q;
   logic             err_q;
   logic             scan_load, scan_shift, scan_msb, scan_empty, scan_last;

   exp_bit_scanner #(.EXP_WIDTH(EXP_WIDTH)) u_scanner (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .load       (scan_load),
      .shift      (scan_shift),
      .load_value (exponent_in),
      .msb        (scan_msb),
      .empty      (scan_empty),
      .last       (scan_last)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      scan_load  = 1'b0;
      scan_shift = 1'b0;
      case (state)
         IDLE: if (start_in) begin
            scan_load  = 1'b1;
            next_state = (modulus_in == '0) ? DONE : SCAN;
         end
         // Leading zeros are consumed one per cycle without issuing work.
         SCAN: begin
            if (scan_empty)    next_state = DONE;
            else if (scan_msb) next_state = SQ_ISSUE;
            else               scan_shift = 1'b1;
         end
         SQ_ISSUE:  next_state = SQ_WAIT;
         SQ_WAIT:   if (unit.sq_valid_in) next_state = scan_msb ? MUL_ISSUE : NEXT;
         MUL_ISSUE: next_state = MUL_WAIT;
         MUL_WAIT:  if (unit.mul_valid_in) next_state = NEXT;
         // 'last' is checked before the shift lands: the new count is zero.
         NEXT: begin
            scan_shift = 1'b1;
            next_state = scan_last ? DONE : SQ_ISSUE;
         end
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc        <= '0;
         base_q     <= '0;
         mod_q      <= '0;
         err_q      <= 1'b0;
         result_out <= '0;
         busy_out   <= 1'b0;
         valid_out  <= 1'b0;
         error_out  <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: if (start_in) begin
               base_q    <= base_in;
               mod_q     <= modulus_in;
               acc       <= WIDTH'(1);
               err_q     <= (modulus_in == '0);
               busy_out  <= 1'b1;
               error_out <= 1'b0;
            end
            SQ_WAIT:  if (unit.sq_valid_in)  acc <= unit.sq_result_in;
            MUL_WAIT: if (unit.mul_valid_in) acc <= unit.mul_result_in;
            // acc starts at 1, which is not reduced when mod == 1.
            DONE: begin
               result_out <= (err_q || mod_q == WIDTH'(1)) ? '0 : acc;
               error_out  <= err_q;
               valid_out  <= 1'b1;
               busy_out   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Operands come straight from registers that only change on a result,
   // so they are stable from trigger until the matching valid.
   assign unit.sq_ready_out    = (state == SQ_ISSUE);
   assign unit.sq_value_out    = acc;
   assign unit.sq_modulus_out  = mod_q;
   assign unit.mul_ready_out   = (state == MUL_ISSUE);
   assign unit.mul_a_out       = acc;
   assign unit.mul_b_out       = base_q;
   assign unit.mul_modulus_out = mod_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;
   import keychain_pkg::*;
   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] base = '0, expo = '0, modulus = '0;
   logic [W-1:0] result;
   logic         busy, valid, error;

   modexp_ctrl_if #(.WIDTH(W)) uif();

   // Unit models drive *_m; spur_* inject stray done pulses with junk data.
   logic         sq_vld_m = 1'b0, spur_sq_idle = 1'b0, spur_sq_mul = 1'b0;
   logic [W-1:0] sq_res_m = '0;
   logic         mul_vld_m = 1'b0, spur_mul_sq = 1'b0;
   logic [W-1:0] mul_res_m = '0;

   assign uif.sq_valid_in   = sq_vld_m | spur_sq_idle | spur_sq_mul;
   assign uif.sq_result_in  = (spur_sq_idle | spur_sq_mul) ? 16'hBEEF : sq_res_m;
   assign uif.mul_valid_in  = mul_vld_m | spur_mul_sq;
   assign uif.mul_result_in = spur_mul_sq ? 16'hBEEF : mul_res_m;

   modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(W)) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .start_in    (start),
      .base_in     (base),
      .exponent_in (expo),
      .modulus_in  (modulus),
      .result_out  (result),
      .busy_out    (busy),
      .valid_out   (valid),
      .error_out   (error),
      .unit        (uif.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int sq_cnt = 0, mul_cnt = 0;
   bit inject = 1'b0;
   bit prev_sq = 1'b0, prev_mul = 1'b0, prev_valid = 1'b0;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [W-1:0] b, e, m, res;
      logic         err;
      int           nsq, nmul;
   } vec_t;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Right-to-left reference, independent of the DUT's scan order.
   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, e, m);
      longint unsigned r, p;
      if (m == '0) return '0;
      r = 1 % longint'(m);
      p = longint'(b) % longint'(m);
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * p) % longint'(m);
         p = (p * p) % longint'(m);
      end
      return W'(r);
   endfunction

   // Monitor: trigger counting/shape and scoreboard on valid.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (uif.sq_ready_out) begin
            sq_cnt++;
            chk("trigger_exclusive", uif.mul_ready_out, 0);
            chk("sq_trigger_width", prev_sq, 0);
         end
         if (uif.mul_ready_out) begin
            mul_cnt++;
            chk("mul_trigger_width", prev_mul, 0);
         end
         if (valid) begin
            chk("valid_width", prev_valid, 0);
            chk("busy_low_at_valid", busy, 0);
            if (sb.size() == 0) chk("unexpected_valid", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("error", error, e.err);
            end
         end
      end
      prev_sq    = uif.sq_ready_out;
      prev_mul   = uif.mul_ready_out;
      prev_valid = valid;
   end

   initial begin : sq_model
      logic [W-1:0] v, m;
      int lat;
      bit abort;
      forever begin
         @(negedge clk);
         if (rst_n && uif.sq_ready_out) begin
            v = uif.sq_value_out;
            m = uif.sq_modulus_out;
            lat = inject ? int'($urandom_range(2, 8)) : int'($urandom_range(1, 8));
            abort = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               spur_mul_sq = 1'b0;
               if (!rst_n) begin abort = 1'b1; break; end
               chk("sq_value_stable", uif.sq_value_out, v);
               chk("sq_modulus_stable", uif.sq_modulus_out, m);
               if (inject && i == 0) spur_mul_sq = 1'b1;
            end
            spur_mul_sq = 1'b0;
            if (!abort) begin
               sq_res_m = W'((longint'(v) * longint'(v)) % longint'(m));
               sq_vld_m = 1'b1;
               @(negedge clk);
               sq_vld_m = 1'b0;
            end
         end
      end
   end

   initial begin : mul_model
      logic [W-1:0] a, b, m;
      int lat;
      bit abort;
      forever begin
         @(negedge clk);
         if (rst_n && uif.mul_ready_out) begin
            a = uif.mul_a_out;
            b = uif.mul_b_out;
            m = uif.mul_modulus_out;
            lat = inject ? int'($urandom_range(2, 8)) : int'($urandom_range(1, 8));
            abort = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               spur_sq_mul = 1'b0;
               if (!rst_n) begin abort = 1'b1; break; end
               chk("mul_a_stable", uif.mul_a_out, a);
               chk("mul_b_stable", uif.mul_b_out, b);
               chk("mul_modulus_stable", uif.mul_modulus_out, m);
               if (inject && i == 0) spur_sq_mul = 1'b1;
            end
            spur_sq_mul = 1'b0;
            if (!abort) begin
               mul_res_m = W'((longint'(a) * longint'(b)) % longint'(m));
               mul_vld_m = 1'b1;
               @(negedge clk);
               mul_vld_m = 1'b0;
            end
         end
      end
   end

   task automatic wait_valid(input string name);
      bit got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (valid) begin got = 1'b1; break; end
      end
      chk({name, "_completion"}, got, 1);
      if (!got && sb.size() > 0) void'(sb.pop_front());
   endtask

   task automatic run_job(input string name, input vec_t v);
      int sq0, mul0;
      @(negedge clk);
      base = v.b; expo = v.e; modulus = v.m; start = 1'b1;
      sb.push_back('{v.res, v.err});
      sq0 = sq_cnt; mul0 = mul_cnt;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_busy"}, busy, 1);
      chk({name, "_error_cleared"}, error, 0);
      wait_valid(name);
      chk({name, "_squares"}, sq_cnt - sq0, v.nsq);
      chk({name, "_multiplies"}, mul_cnt - mul0, v.nmul);
      @(negedge clk);
      chk({name, "_result_held"}, result, v.res);
   endtask

   function automatic vec_t mk_rand();
      vec_t v;
      v.b = W'($urandom);
      v.e = W'($urandom);
      v.m = W'($urandom_range(2, 65535));
      v.res = ref_modexp(v.b, v.e, v.m);
      v.err = 1'b0;
      v.nsq = 0;
      for (int i = 0; i < W; i++) if (v.e[i]) v.nsq = i + 1;
      v.nmul = $countones(v.e);
      return v;
   endfunction

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      vec_t vecs[10];
      vec_t v;
      int sq0, mul0;
      bit got, seen;

      vecs[0] = '{16'd4,     16'd13,     16'd497,   16'd445, 1'b0, 4,  3};
      vecs[1] = '{16'd4,     16'd0,      16'd497,   16'd1,   1'b0, 0,  0};
      vecs[2] = '{16'd4,     16'd0,      16'd1,     16'd0,   1'b0, 0,  0};
      vecs[3] = '{16'd500,   16'd1,      16'd497,   16'd3,   1'b0, 1,  1};
      vecs[4] = '{16'd5,     16'd3,      16'd0,     16'd0,   1'b1, 0,  0};
      vecs[5] = '{16'd9,     16'd5,      16'd1,     16'd0,   1'b0, 3,  2};
      vecs[6] = '{16'd3,     16'd200,    16'd1000,  16'd1,   1'b0, 8,  3};
      vecs[7] = '{16'd7,     16'd5,      16'd100,   16'd7,   1'b0, 3,  2};
      vecs[8] = '{16'd2,     16'h8000,   16'hFFFF,  16'd1,   1'b0, 16, 1};
      vecs[9] = '{16'hFFFF,  16'hFFFF,   16'hFFFF,  16'd0,   1'b0, 16, 16};

      // Asynchronous reset, checked before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("reset_result", result, 0);
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid, 0);
      chk("reset_error", error, 0);
      chk("reset_sq_value", uif.sq_value_out, 0);
      chk("reset_sq_ready", uif.sq_ready_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_job($sformatf("vec%0d", i), vecs[i]);

      // Stray done pulses inside the other unit's wait state.
      inject = 1'b1;
      run_job("spur_in_wait", vecs[0]);
      inject = 1'b0;

      // Stray squarer done while idle: acc (sq operand) must not move.
      run_job("pre_idle_spur", vecs[0]);
      sq0 = sq_cnt; mul0 = mul_cnt;
      @(negedge clk) spur_sq_idle = 1'b1;
      @(negedge clk) spur_sq_idle = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_spur_acc", uif.sq_value_out, 445);
      chk("idle_spur_busy", busy, 0);
      chk("idle_spur_triggers", (sq_cnt - sq0) + (mul_cnt - mul0), 0);

      // start held high: no re-capture, back-to-back job on the valid cycle.
      @(negedge clk);
      base = 16'd4; expo = 16'd13; modulus = 16'd497; start = 1'b1;
      sb.push_back('{16'd445, 1'b0});
      sb.push_back('{16'd7, 1'b0});
      sq0 = sq_cnt; mul0 = mul_cnt;
      @(negedge clk);
      base = 16'd7; expo = 16'd5; modulus = 16'd100;
      chk("held_busy", busy, 1);
      wait_valid("held_first");
      chk("held_first_squares", sq_cnt - sq0, 4);
      chk("held_first_multiplies", mul_cnt - mul0, 3);
      sq0 = sq_cnt; mul0 = mul_cnt;
      @(negedge clk);
      chk("held_second_accepted", busy, 1);
      start = 1'b0;
      wait_valid("held_second");
      chk("held_second_squares", sq_cnt - sq0, 3);
      chk("held_second_multiplies", mul_cnt - mul0, 2);
      repeat (2) @(negedge clk);
      chk("held_no_third", busy, 0);

      // Reset in MUL_WAIT abandons the job.
      @(negedge clk);
      base = 16'd4; expo = 16'd13; modulus = 16'd497; start = 1'b1;
      sb.push_back('{16'd445, 1'b0});
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (uif.mul_ready_out) begin got = 1'b1; break; end
      end
      chk("reset_reach_mul", got, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_result", result, 0);
      chk("midrst_mul_a", uif.mul_a_out, 0);
      chk("midrst_mul_b", uif.mul_b_out, 0);
      chk("midrst_mul_ready", uif.mul_ready_out, 0);
      void'(sb.pop_back());
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         seen = seen | valid;
      end
      chk("midrst_no_valid", seen, 0);
      run_job("post_reset", vecs[6]);

      for (int i = 0; i < 5; i++) begin
         v = mk_rand();
         run_job($sformatf("rand%0d", i), v);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
